// File: rtl/bus_demux_responder.sv
// Rebuilds a 16-bit address from the CPU's multiplexed byte bus and runs one req/ack memory transaction per address.
// Latency: phase-low sample -> mem_req 1 cycle, read ack -> bus_db_oe 1 cycle; no backpressure, high bytes arriving mid-transaction are dropped and flagged.
module bus_demux_responder #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [7:0]  OPEN_BUS = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  bus_ab,
    input  logic        bus_phase,
    input  logic        bus_rw,
    input  logic [7:0]  bus_db_in,
    output logic [7:0]  bus_db_out,
    output logic        bus_db_oe,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    output logic        mem_req,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        err_timeout,
    output logic        err_overrun
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, HI, REQ, DRIVE} state_t;

    state_t        state;
    logic [7:0]    addr_hi;
    logic [CW-1:0] req_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            addr_hi     <= '0;
            req_cnt     <= '0;
            bus_db_out  <= '0;
            bus_db_oe   <= 1'b0;
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
            mem_req     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus_phase) begin
                        addr_hi <= bus_ab;
                        state   <= HI;
                    end
                end
                HI: begin
                    if (bus_phase) begin
                        addr_hi <= bus_ab;
                    end else begin
                        mem_addr  <= {addr_hi, bus_ab};
                        mem_we    <= ~bus_rw;
                        mem_wdata <= bus_db_in;
                        mem_req   <= 1'b1;
                        req_cnt   <= CW'(1);
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (bus_phase)
                        err_overrun <= 1'b1;
                    // An ack on the final allowed cycle still counts as a completion.
                    if (mem_ack || req_cnt == CW'(TIMEOUT)) begin
                        mem_req <= 1'b0;
                        if (!mem_ack)
                            err_timeout <= 1'b1;
                        if (!mem_we) begin
                            bus_db_out <= mem_ack ? mem_rdata : OPEN_BUS;
                            bus_db_oe  <= 1'b1;
                            state      <= DRIVE;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        req_cnt <= req_cnt + 1'b1;
                    end
                end
                DRIVE: begin
                    if (bus_phase) begin
                        bus_db_oe <= 1'b0;
                        addr_hi   <= bus_ab;
                        state     <= HI;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_demux_responder.sv
// Transaction-level bench for bus_demux_responder: directed scenarios plus randomized transactions.
module tb_bus_demux_responder;

    localparam int         TO = 4;
    localparam logic [7:0] OB = 8'hFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  bus_ab = '0;
    logic        bus_phase = 1'b0;
    logic        bus_rw = 1'b0;
    logic [7:0]  bus_db_in = '0;
    logic [7:0]  bus_db_out;
    logic        bus_db_oe;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        mem_req;
    logic [7:0]  mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        err_timeout;
    logic        err_overrun;

    int vectors = 0;
    int miscompares = 0;
    logic exp_to = 1'b0;
    logic exp_ov = 1'b0;

    bus_demux_responder #(.TIMEOUT(TO), .OPEN_BUS(OB)) dut (
        .clk(clk), .rst(rst), .bus_ab(bus_ab), .bus_phase(bus_phase), .bus_rw(bus_rw),
        .bus_db_in(bus_db_in), .bus_db_out(bus_db_out), .bus_db_oe(bus_db_oe),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_req(mem_req),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err_timeout(err_timeout),
        .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full bus transaction. delay = REQ cycles before ack (>= TO means never acked);
    // ovr_at = REQ cycle in which a stray high byte is driven (0 = none).
    task automatic run_txn(input logic [7:0] hi, input int n_extra, input logic [7:0] lo,
                           input logic rw, input logic [7:0] wd, input int delay,
                           input logic [7:0] rd, input int ovr_at);
        logic [15:0] exp_addr;
        logic        timed_out;
        logic [7:0]  exp_dout;
        int          exp_cycles;
        int          cycles;
        exp_addr   = {hi, lo};
        timed_out  = (delay + 1 > TO);
        exp_cycles = timed_out ? TO : delay + 1;
        exp_dout   = timed_out ? OB : rd;
        for (int i = 0; i < n_extra; i++) begin
            bus_phase = 1'b1; bus_ab = 8'($urandom); tick();
        end
        bus_phase = 1'b1; bus_ab = hi; tick();
        vectors++;
        if (bus_db_oe !== 1'b0 || mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL hi_phase: oe=%b req=%b, required oe=0 req=0", bus_db_oe, mem_req);
        end
        bus_phase = 1'b0; bus_ab = lo; bus_rw = rw; bus_db_in = wd; tick();
        bus_rw = $urandom_range(0, 1); bus_db_in = 8'($urandom);
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== exp_addr || mem_we !== ~rw ||
            (!rw && mem_wdata !== wd)) begin
            miscompares++;
            $display("FAIL req_start: req=%b addr=%h we=%b wdata=%h, required req=1 addr=%h we=%b wdata=%h",
                     mem_req, mem_addr, mem_we, mem_wdata, exp_addr, ~rw, wd);
        end
        cycles = 0;
        while (mem_req === 1'b1 && cycles < 40) begin
            cycles++;
            mem_ack   = (!timed_out && cycles == delay + 1);
            mem_rdata = mem_ack ? rd : 8'($urandom);
            bus_phase = (cycles == ovr_at);
            bus_ab    = 8'($urandom);
            tick();
            if (mem_req === 1'b1) begin
                vectors++;
                if (mem_addr !== exp_addr || mem_we !== ~rw) begin
                    miscompares++;
                    $display("FAIL req_stable: addr=%h we=%b, required addr=%h we=%b",
                             mem_addr, mem_we, exp_addr, ~rw);
                end
            end
        end
        mem_ack = 1'b0; bus_phase = 1'b0;
        if (ovr_at >= 1 && ovr_at <= exp_cycles) exp_ov = 1'b1;
        if (timed_out) exp_to = 1'b1;
        vectors++;
        if (cycles !== exp_cycles) begin
            miscompares++;
            $display("FAIL req_len: req high %0d cycles, required %0d", cycles, exp_cycles);
        end
        vectors++;
        if (err_timeout !== exp_to || err_overrun !== exp_ov) begin
            miscompares++;
            $display("FAIL flags: timeout=%b overrun=%b, required timeout=%b overrun=%b",
                     err_timeout, err_overrun, exp_to, exp_ov);
        end
        vectors++;
        if (bus_db_oe !== rw || (rw && bus_db_out !== exp_dout) || mem_addr !== exp_addr) begin
            miscompares++;
            $display("FAIL completion: oe=%b dout=%h addr=%h, required oe=%b dout=%h addr=%h",
                     bus_db_oe, bus_db_out, mem_addr, rw, exp_dout, exp_addr);
        end
        // Ack outside REQ and a stray low byte must both be ignored.
        mem_ack = 1'b1; mem_rdata = ~exp_dout; tick();
        mem_ack = 1'b0; bus_ab = 8'($urandom); tick();
        vectors++;
        if (mem_req !== 1'b0 || bus_db_oe !== rw || (rw && bus_db_out !== exp_dout)) begin
            miscompares++;
            $display("FAIL idle_hold: req=%b oe=%b dout=%h, required req=0 oe=%b dout=%h",
                     mem_req, bus_db_oe, bus_db_out, rw, exp_dout);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus_phase = 1'b1; bus_ab = 8'h5C; tick(); tick();
        vectors++;
        if (bus_db_out !== 8'h00 || bus_db_oe !== 1'b0 || mem_addr !== 16'h0000 ||
            mem_we !== 1'b0 || mem_wdata !== 8'h00 || mem_req !== 1'b0 ||
            err_timeout !== 1'b0 || err_overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: dout=%h oe=%b addr=%h we=%b wdata=%h req=%b to=%b ov=%b, required all 0",
                     bus_db_out, bus_db_oe, mem_addr, mem_we, mem_wdata, mem_req, err_timeout, err_overrun);
        end
        rst = 1'b0; bus_phase = 1'b0; tick();
    endtask

    task automatic test_read();
        run_txn(8'h12, 0, 8'h34, 1'b1, 8'h00, 2, 8'hA9, 0);
    endtask

    task automatic test_write();
        run_txn(8'h80, 0, 8'h00, 1'b0, 8'h5A, 0, 8'h00, 0);
    endtask

    task automatic test_timeout();
        run_txn(8'hFF, 0, 8'hFC, 1'b1, 8'h00, TO + 3, 8'h00, 0);
        run_txn(8'h40, 0, 8'h01, 1'b0, 8'h77, TO, 8'h00, 0);
        run_txn(8'h41, 0, 8'h02, 1'b1, 8'h00, TO - 1, 8'h3C, 0);
    endtask

    task automatic test_sequencing();
        bus_phase = 1'b0; bus_ab = 8'h99; tick(); tick();
        vectors++;
        if (mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL stray_low: req=%b, required 0", mem_req);
        end
        bus_phase = 1'b1; bus_ab = 8'h11; tick();
        run_txn(8'h22, 0, 8'h33, 1'b1, 8'h00, 1, 8'h6E, 0);
    endtask

    task automatic test_overrun();
        run_txn(8'h56, 0, 8'h78, 1'b1, 8'h00, 2, 8'hC3, 1);
        run_txn(8'h9A, 0, 8'hBC, 1'b0, 8'hE1, 1, 8'h00, 2);
    endtask

    task automatic test_reset_in_req();
        bus_phase = 1'b1; bus_ab = 8'hAB; tick();
        bus_phase = 1'b0; bus_ab = 8'hCD; bus_rw = 1'b1; tick();
        vectors++;
        if (mem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_setup: req=%b, required 1", mem_req);
        end
        rst = 1'b1; tick();
        rst = 1'b0; exp_to = 1'b0; exp_ov = 1'b0;
        vectors++;
        if (mem_req !== 1'b0 || bus_db_oe !== 1'b0 || err_timeout !== 1'b0 ||
            err_overrun !== 1'b0 || mem_addr !== 16'h0000) begin
            miscompares++;
            $display("FAIL rst_in_req: req=%b oe=%b to=%b ov=%b addr=%h, required all 0",
                     mem_req, bus_db_oe, err_timeout, err_overrun, mem_addr);
        end
        run_txn(8'h0F, 0, 8'hF0, 1'b1, 8'h00, 0, 8'h42, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int d;
            int ovr;
            d   = $urandom_range(0, TO + 1);
            ovr = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TO) : 0;
            if ($urandom_range(0, 4) == 0) begin
                bus_phase = 1'b0; bus_ab = 8'($urandom); tick();
            end
            run_txn(8'($urandom), $urandom_range(0, 2), 8'($urandom), 1'($urandom_range(0, 1)),
                    8'($urandom), d, 8'($urandom), ovr);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_sequencing();
        test_overrun();
        test_reset_in_req();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
